// File: rtl/mem_byte_access_master_if.sv
// mem_byte_access_master_if: valid/ready byte-wide data memory port
interface mem_byte_access_master_if #(parameter int ADDR_W = 9) ();
   logic              m_valid;
   logic              m_rw;
   logic [ADDR_W-1:0] m_addr;
   logic [7:0]        m_wdata;
   logic              m_ready;
   logic [7:0]        m_rdata;
   modport master (output m_valid, m_rw, m_addr, m_wdata, input m_ready, m_rdata);
   modport slave  (input m_valid, m_rw, m_addr, m_wdata, output m_ready, m_rdata);
endinterface

// File: rtl/mem_byte_access_master.sv
// mem_byte_access_master: MEM-stage load/store sequenced as 1/2/4 big-endian byte transfers
module mem_byte_access_master #(
   parameter int ADDR_W      = 9,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic        Clk,
   input  logic        R,
   input  logic        mem_req,
   input  logic        rw,
   input  logic [1:0]  size,
   input  logic        se,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   mem_byte_access_master_if.master m
);
   typedef enum logic [1:0] {IDLE, BUSY, FINISH, FAULT} state_t;
   localparam int WW = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WW-1:0] WMAX = WW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
   state_t            state_q, state_d;
   logic              rw_q, rw_d, se_q, se_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d, asm_q, asm_d, rdata_q, rdata_d;
   logic [1:0]        cnt_q, cnt_d, idx_q, idx_d;
   logic [WW-1:0]     wait_q, wait_d;
   logic              busy, bad;
   logic [1:0]        sel;
   logic [31:0]       asm_nx, ext;
   logic              unused_addr;
   assign unused_addr = ^addr[31:ADDR_W];
   assign busy   = state_q == BUSY;
   assign bad    = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
   // cnt_q holds N-1, so cnt_q - idx_q picks the byte lane, most significant first
   assign sel    = cnt_q - idx_q;
   assign asm_nx = {asm_q[23:0], m.m_rdata};
   assign ext    = cnt_q == 2'd0 ? {{24{se_q & asm_nx[7]}}, asm_nx[7:0]} :
                   cnt_q == 2'd1 ? {{16{se_q & asm_nx[15]}}, asm_nx[15:0]} : asm_nx;
   assign stall     = state_q == IDLE ? mem_req : busy;
   assign done      = state_q == FINISH || state_q == FAULT;
   assign err       = state_q == FAULT;
   assign rdata     = rdata_q;
   assign m.m_valid = busy;
   assign m.m_rw    = busy & rw_q;
   assign m.m_addr  = busy ? addr_q + ADDR_W'(idx_q) : '0;
   assign m.m_wdata = busy ? wdata_q[{sel, 3'b000} +: 8] : '0;
   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      se_d    = se_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      asm_d   = asm_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: if (mem_req) begin
            if (bad) state_d = FAULT;
            else begin
               state_d = BUSY;
               rw_d    = rw;
               se_d    = se;
               addr_d  = addr[ADDR_W-1:0];
               wdata_d = wdata;
               cnt_d   = size == 2'b00 ? 2'd0 : size == 2'b01 ? 2'd1 : 2'd3;
               idx_d   = '0;
               wait_d  = '0;
               asm_d   = '0;
            end
         end
         BUSY: if (m.m_ready) begin
            wait_d = '0;
            asm_d  = rw_q ? asm_q : asm_nx;
            if (idx_q == cnt_q) begin
               state_d = FINISH;
               rdata_d = rw_q ? rdata_q : ext;
            end else idx_d = idx_q + 2'd1;
         end else if (TIMEOUT_CYC != 0 && wait_q == WMAX) state_d = FAULT;
         else wait_d = wait_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (!R) begin
         state_q <= IDLE;
         rw_q    <= 1'b0;
         se_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         asm_q   <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
         se_q    <= se_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         asm_q   <= asm_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
      end
   end
endmodule
